// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MDU_MADD_EN to add
// MADD/MADDU/MSUB/MSUBU (extra ACC cycle and 2*DATA_WIDTH accumulator).
module mult_div_unit #(
  parameter int DATA_WIDTH         = 32,
  parameter int MUL_LATENCY        = 2,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  flush,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  busy
);
  localparam int DW         = DATA_WIDTH;
  localparam int DIV_CYCLES = DW / DIV_BITS_PER_CYCLE;
  localparam int CW         = $clog2(DW + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
`ifdef MDU_MADD_EN
  localparam logic [5:0] FUNCT2_MADD  = 6'h00;
  localparam logic [5:0] FUNCT2_MADDU = 6'h01;
  localparam logic [5:0] FUNCT2_MSUB  = 6'h04;
  localparam logic [5:0] FUNCT2_MSUBU = 6'h05;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
`ifdef MDU_MADD_EN
    S_ACC,
`endif
    S_DIV,
    S_FIX
  } state_t;

  state_t state, state_n;

  logic          dec_mul, dec_div, dec_sgn, dec_mthi, dec_mtlo, recog, accept;
  logic [CW-1:0] cnt;
  logic          op_sgn_q;
  logic [DW-1:0] a_q, b_q;
  logic [DW:0]   rem_q, rem_c;
  logic [DW-1:0] quo_q, quo_c, dvs_q;
`ifdef MDU_MADD_EN
  logic            dec_acc, dec_sub, op_acc_q, op_sub_q;
  logic [2*DW-1:0] prod_q, acc_sum;
`endif

  always_comb begin
    dec_mul  = 1'b0;
    dec_div  = 1'b0;
    dec_sgn  = 1'b0;
    dec_mthi = 1'b0;
    dec_mtlo = 1'b0;
`ifdef MDU_MADD_EN
    dec_acc  = 1'b0;
    dec_sub  = 1'b0;
`endif
    case (funct)
      FUNCT_MTHI:   dec_mthi = 1'b1;
      FUNCT_MTLO:   dec_mtlo = 1'b1;
      FUNCT_MULT:   begin dec_mul = 1'b1; dec_sgn = 1'b1; end
      FUNCT_MULTU:  dec_mul = 1'b1;
      FUNCT_DIV:    begin dec_div = 1'b1; dec_sgn = 1'b1; end
      FUNCT_DIVU:   dec_div = 1'b1;
`ifdef MDU_MADD_EN
      FUNCT2_MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = 1'b1; end
      FUNCT2_MADDU: begin dec_mul = 1'b1; dec_acc = 1'b1; end
      FUNCT2_MSUB:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
      FUNCT2_MSUBU: begin dec_mul = 1'b1; dec_acc = 1'b1; dec_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign recog  = dec_mul | dec_div | dec_mthi | dec_mtlo;
  assign accept = en && (state == S_IDLE) && recog && !flush;
  assign busy   = (state != S_IDLE);

  // Signed/unsigned merged multiply: sign-extend to DW+1, then to the full product width.
  logic [DW:0]     ma, mb;
  logic [2*DW-1:0] ma_w, mb_w, product;
  assign ma      = {op_sgn_q & a_q[DW-1], a_q};
  assign mb      = {op_sgn_q & b_q[DW-1], b_q};
  assign ma_w    = {{(DW-1){ma[DW]}}, ma};
  assign mb_w    = {{(DW-1){mb[DW]}}, mb};
  assign product = ma_w * mb_w;

`ifdef MDU_MADD_EN
  assign acc_sum = op_sub_q ? ({hi, lo} - prod_q) : ({hi, lo} + prod_q);
`endif

  // Divider works on magnitudes; signs are restored in FIX.
  logic [DW-1:0] abs_a, abs_b, fix_q, fix_r;
  logic          neg_a, neg_b;
  assign abs_a = (dec_sgn & operand_a[DW-1]) ? -operand_a : operand_a;
  assign abs_b = (dec_sgn & operand_b[DW-1]) ? -operand_b : operand_b;
  assign neg_a = op_sgn_q & a_q[DW-1];
  assign neg_b = op_sgn_q & b_q[DW-1];
  assign fix_q = (neg_a ^ neg_b) ? -quo_q : quo_q;
  assign fix_r = neg_a ? -rem_q[DW-1:0] : rem_q[DW-1:0];

  always_comb begin
    rem_c = rem_q;
    quo_c = quo_q;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      rem_c = {rem_c[DW-1:0], quo_c[DW-1]};
      quo_c = {quo_c[DW-2:0], 1'b0};
      if (rem_c >= {1'b0, dvs_q}) begin
        rem_c    = rem_c - {1'b0, dvs_q};
        quo_c[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    stall_req = 1'b0;
    case (state)
      S_IDLE: if (accept && (dec_mul || dec_div)) begin
        state_n   = dec_mul ? S_MUL : S_DIV;
        stall_req = 1'b1;
      end
      S_MUL: if (cnt == MUL_LAST) begin
`ifdef MDU_MADD_EN
        if (op_acc_q) begin
          state_n   = S_ACC;
          stall_req = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
`else
        state_n = S_IDLE;
`endif
      end else begin
        stall_req = 1'b1;
      end
`ifdef MDU_MADD_EN
      S_ACC: state_n = S_IDLE;
`endif
      S_DIV: begin
        stall_req = 1'b1;
        if (cnt == DIV_LAST) state_n = S_FIX;
      end
      S_FIX:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n   = S_IDLE;
      stall_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      op_sgn_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
`ifdef MDU_MADD_EN
      op_acc_q <= 1'b0;
      op_sub_q <= 1'b0;
      prod_q   <= '0;
`endif
    end else if (flush) begin
      cnt <= '0;
    end else begin
      if (state_n == state && (state == S_MUL || state == S_DIV)) cnt <= cnt + CW'(1);
      else                                                          cnt <= '0;
      case (state)
        S_IDLE: if (accept) begin
          op_sgn_q <= dec_sgn;
          a_q      <= operand_a;
          b_q      <= operand_b;
          rem_q    <= '0;
          quo_q    <= abs_a;
          dvs_q    <= abs_b;
`ifdef MDU_MADD_EN
          op_acc_q <= dec_acc;
          op_sub_q <= dec_sub;
`endif
          if (dec_mthi) hi <= operand_a;
          if (dec_mtlo) lo <= operand_a;
        end
        S_MUL: if (cnt == MUL_LAST) begin
`ifdef MDU_MADD_EN
          if (op_acc_q) prod_q   <= product;
          else          {hi, lo} <= product;
`else
          {hi, lo} <= product;
`endif
        end
`ifdef MDU_MADD_EN
        S_ACC: {hi, lo} <= acc_sum;
`endif
        S_DIV: begin
          rem_q <= rem_c;
          quo_q <= quo_c;
        end
        S_FIX: if (b_q == '0) begin
          lo <= '1;
          hi <= a_q;
        end else begin
          lo <= fix_q;
          hi <= fix_r;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table with scoreboard, plus
// flush and reset corner sequences.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic [5:0]  funct;
  logic [31:0] operand_a, operand_b, hi, lo;
  logic        stall_req, busy;

  int n_chk  = 0;
  int n_fail = 0;

  mult_div_unit #(.DATA_WIDTH(32), .MUL_LATENCY(2), .DIV_BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .funct(funct),
    .operand_a(operand_a), .operand_b(operand_b),
    .stall_req(stall_req), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a, b, hi, lo;
    int          stalls;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    int          stalls;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  function automatic vec_t mk(input logic [5:0] f, input logic [31:0] a, b, h, l, input int s);
    vec_t v;
    v.funct = f; v.a = a; v.b = b; v.hi = h; v.lo = l; v.stalls = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    exp_t e;
    int   st;
    bit   done;
    e.hi = v.hi; e.lo = v.lo; e.stalls = v.stalls;
    sb.push_back(e);
    @(negedge clk);
    en = 1'b1; funct = v.funct; operand_a = v.a; operand_b = v.b;
    st = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (stall_req) begin
        st++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: stall_req still high after %0d cycles", tag, st);
    end
    @(posedge clk); #1;
    en = 1'b0;
    e = sb.pop_front();
    chk($sformatf("%s stalls", tag), 64'(st), 64'(e.stalls));
    chk($sformatf("%s hi", tag), {32'h0, hi}, {32'h0, e.hi});
    chk($sformatf("%s lo", tag), {32'h0, lo}, {32'h0, e.lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] keep_hi, keep_lo;
    vecs[0]  = mk(6'h18, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2);
    vecs[1]  = mk(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2);
    vecs[2]  = mk(6'h18, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 2);
    vecs[3]  = mk(6'h1a, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    vecs[4]  = mk(6'h1a, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33);
    vecs[5]  = mk(6'h1b, 32'h5,        32'h0,        32'h00000005, 32'hFFFFFFFF, 33);
    vecs[6]  = mk(6'h1a, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, 33);
    vecs[7]  = mk(6'h1a, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    vecs[8]  = mk(6'h1b, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33);
    vecs[9]  = mk(6'h20, 32'h1,        32'h1,        32'h00000002, 32'h0000000E, 0);
    vecs[10] = mk(6'h11, 32'h12345678, 32'h0,        32'h12345678, 32'h0000000E, 0);
    vecs[11] = mk(6'h13, 32'h0,        32'h0,        32'h12345678, 32'h00000000, 0);
`ifdef MDU_MADD_EN
    vecs[12] = mk(6'h01, 32'h2,        32'h3,        32'h12345678, 32'h00000006, 3);
    vecs[13] = mk(6'h04, 32'h1,        32'h7,        32'h12345677, 32'hFFFFFFFF, 3);
`else
    vecs[12] = mk(6'h01, 32'h2,        32'h3,        32'h12345678, 32'h00000000, 0);
    vecs[13] = mk(6'h04, 32'h1,        32'h7,        32'h12345678, 32'h00000000, 0);
`endif

    rst = 1'b1; en = 1'b0; flush = 1'b0; funct = 6'h0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", {32'h0, hi}, 64'h0);
    chk("reset lo", {32'h0, lo}, 64'h0);
    chk("reset busy", {63'h0, busy}, 64'h0);
    chk("reset stall", {63'h0, stall_req}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    keep_hi = vecs[13].hi;
    keep_lo = vecs[13].lo;

    // Flush a divide at T+10: no stall in the flush cycle, idle after, no late write.
    @(negedge clk);
    en = 1'b1; funct = 6'h1b; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("div busy before flush", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    #1;
    chk("flush stall", {63'h0, stall_req}, 64'h0);
    @(posedge clk); #1;
    flush = 1'b0; en = 1'b0;
    chk("flush busy", {63'h0, busy}, 64'h0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush hi", {32'h0, hi}, {32'h0, keep_hi});
    chk("flush lo", {32'h0, lo}, {32'h0, keep_lo});

    // Flush wins over an accept in IDLE.
    @(negedge clk);
    en = 1'b1; flush = 1'b1; funct = 6'h11; operand_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    en = 1'b0; flush = 1'b0;
    chk("flush vs mthi hi", {32'h0, hi}, {32'h0, keep_hi});
    chk("flush vs mthi busy", {63'h0, busy}, 64'h0);

    // Reset in the middle of a multiply clears hi/lo.
    @(negedge clk);
    en = 1'b1; funct = 6'h18; operand_a = 32'd3; operand_b = 32'd5;
    @(posedge clk); #1;
    chk("mul busy", {63'h0, busy}, 64'h1);
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst mid mul hi", {32'h0, hi}, 64'h0);
    chk("rst mid mul lo", {32'h0, lo}, 64'h0);
    chk("rst mid mul busy", {63'h0, busy}, 64'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst no late write lo", {32'h0, lo}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage. Owns the architectural HI/LO registers.
- Consumes the decoded FUNCT value from the ID-stage funct generator plus two operands.
- Multiplier pipeline depth and divider radix are parametrised.
- Raises a stall request to the pipeline controller while an operation is in flight.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width; must be even and >= 8
MUL_LATENCY, 2, cycles spent in MUL state (1..4)
DIV_BITS_PER_CYCLE, 1, quotient bits retired per DIV cycle (1 or 2); must divide DATA_WIDTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  valid instruction present in EX this cycle
flush  in  1  kill in-flight op (exception/eret)
funct  in  6  FUNCT code from ID (funct.v encodings)
operand_a  in  DATA_WIDTH  rs value
operand_b  in  DATA_WIDTH  rt value
stall_req  out  1  hold EX and earlier stages
hi  out  DATA_WIDTH  HI register
lo  out  DATA_WIDTH  LO register
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (and flush): state IDLE, counter 0. stall_req 0, busy 0.
  - Reset only: hi = lo = 0.
  - Flush leaves hi/lo unchanged. Flush has priority over en and completion; the op is discarded and no write occurs.
- Recognised codes: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO, FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB, FUNCT2_MSUBU. All other codes are ignored.
- Accept condition: en && state == IDLE && recognised && !flush. Operands and op are latched on the accept edge (cycle T).
- MTHI/MTLO:
  - Single cycle, no stall.
  - hi (resp. lo) <= operand_a at the end of T.
- MULT/MULTU:
  - State MUL for cycles T+1..T+MUL_LATENCY.
  - 2*DATA_WIDTH product, signed or unsigned.
  - {hi,lo} <= product at the end of T+MUL_LATENCY.
- MADD/MSUB (signed/unsigned):
  - As MUL, then one ACC cycle at T+MUL_LATENCY+1.
  - {hi,lo} <= {hi,lo} ± product, modulo 2^(2*DATA_WIDTH).
  - hi/lo are sampled in the ACC cycle.
- DIV/DIVU:
  - State DIV for N = DATA_WIDTH/DIV_BITS_PER_CYCLE cycles, restoring division on magnitudes.
  - Then one FIX cycle applying signs: quotient negated if signs differ; remainder takes the dividend sign.
  - lo <= quotient, hi <= remainder at the end of the FIX cycle (T+N+1).
- Divide by zero: lo = all ones, hi = dividend (unsigned or signed as given). Timing is unchanged.
- Signed overflow (min_int / -1): lo = min_int, hi = 0.
- stall_req (combinational):
  - High in the accept cycle for any multi-cycle op.
  - High in every non-final busy cycle.
  - Low in the final cycle (MUL last / ACC / FIX) so the pipeline advances on the same edge hi/lo are written.
  - Low whenever flush = 1.
- en while busy: ignored; the instruction is held by the stall.
- Same-cycle hazard: a MFHI/MFLO in EX reads the hi/lo outputs, which are registered. The pipeline guarantees ordering through the stall. There is no internal bypass.
- Arithmetic: all intermediate widths are explicit. Sign extension to DATA_WIDTH+1 is done for the signed/unsigned-merged datapath.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are supported as above, including the ACC state.
- Undefined: those four codes are not recognised (no accept, no stall, hi/lo untouched), and the ACC state and accumulator adder are removed.

Test Plan:
1. Reset then MULT, a=0xFFFFFFFE (-2), b=3, MUL_LATENCY=2 -> stall_req high 2 cycles, low in 3rd; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. DIV a=-7 (0xFFFFFFF9), b=2, DIV_BITS_PER_CYCLE=1 -> stall 33 cycles, write in cycle T+33; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
4. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
5. MTHI a=0x12345678 then MADDU a=2, b=3 (MDU_MADD_EN) -> hi=0x12345678, lo=6 after MUL_LATENCY+1 cycles.
6. DIV started, flush asserted at T+10 -> state IDLE next cycle, stall_req 0 in the flush cycle, hi/lo hold prior values; rst mid-MUL -> hi=lo=0.
